// File: rtl/pbl_pkg.sv
// Shared definitions for the register-file stack path: FSM encoding, frame size
// and the register-file index map that fixes push/pop bus order.
package pbl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2
    } st_state_e;

    localparam int unsigned REGS_PER_FRAME = 9;

    localparam int unsigned REG_ACC = 2;
    localparam int unsigned REG_R0  = 3;
    localparam int unsigned REG_R1  = 4;
    localparam int unsigned REG_R2  = 5;
    localparam int unsigned REG_R3  = 6;
    localparam int unsigned REG_R4  = 7;
    localparam int unsigned REG_R5  = 8;
    localparam int unsigned REG_R6  = 9;
    localparam int unsigned REG_R7  = 10;

    // Bus slot inside a frame for a register-file index (ACC lands in slot 0).
    function automatic int unsigned bus_slot(input int unsigned reg_idx);
        return reg_idx - REG_ACC;
    endfunction

endpackage

// File: rtl/reg_stack_mem.sv
// Frame storage for reg_stack: one write port, one asynchronous read address.
module reg_stack_mem
    import pbl_pkg::*;
#(
    parameter int unsigned FRAME_W = 72,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [FRAME_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [FRAME_W-1:0] rdata_o
);

    // Deliberately not reset: contents are undefined until a frame is pushed.
    logic [FRAME_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/reg_stack.sv
// Context-save LIFO: pushes ACC+R0..R7 as one frame, pops by loading the
// restore buses one cycle ahead of a single-cycle st_pop_we strobe.
module reg_stack
    import pbl_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_push,
    input  logic             st_pop,
    input  logic [WIDTH-1:0] st_in1,
    input  logic [WIDTH-1:0] st_in2,
    input  logic [WIDTH-1:0] st_in3,
    input  logic [WIDTH-1:0] st_in4,
    input  logic [WIDTH-1:0] st_in5,
    input  logic [WIDTH-1:0] st_in6,
    input  logic [WIDTH-1:0] st_in7,
    input  logic [WIDTH-1:0] st_in8,
    input  logic [WIDTH-1:0] st_in9,
    output logic [WIDTH-1:0] st_out1,
    output logic [WIDTH-1:0] st_out2,
    output logic [WIDTH-1:0] st_out3,
    output logic [WIDTH-1:0] st_out4,
    output logic [WIDTH-1:0] st_out5,
    output logic [WIDTH-1:0] st_out6,
    output logic [WIDTH-1:0] st_out7,
    output logic [WIDTH-1:0] st_out8,
    output logic [WIDTH-1:0] st_out9,
    output logic             st_pop_we,
    output logic             st_busy,
    output logic             st_full,
    output logic             st_empty,
    output logic [PTR_W-1:0] st_ptr,
    output logic             st_err
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FRAME_W = REGS_PER_FRAME * WIDTH;

    st_state_e            state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic                 err_q;
    logic                 pop_we_q;
    logic [FRAME_W-1:0]   out_q;

    logic [WIDTH-1:0]     in_bus  [REGS_PER_FRAME];
    logic [WIDTH-1:0]     out_bus [REGS_PER_FRAME];
    logic [FRAME_W-1:0]   frame_d;
    logic [FRAME_W-1:0]   rd_frame;
    logic                 full;
    logic                 empty;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 req_clash;

    assign in_bus[bus_slot(REG_ACC)] = st_in1;
    assign in_bus[bus_slot(REG_R0)]  = st_in2;
    assign in_bus[bus_slot(REG_R1)]  = st_in3;
    assign in_bus[bus_slot(REG_R2)]  = st_in4;
    assign in_bus[bus_slot(REG_R3)]  = st_in5;
    assign in_bus[bus_slot(REG_R4)]  = st_in6;
    assign in_bus[bus_slot(REG_R5)]  = st_in7;
    assign in_bus[bus_slot(REG_R6)]  = st_in8;
    assign in_bus[bus_slot(REG_R7)]  = st_in9;

    for (genvar gi = 0; gi < REGS_PER_FRAME; gi++) begin : g_slot
        assign frame_d[gi*WIDTH +: WIDTH] = in_bus[gi];
        assign out_bus[gi]                = out_q[gi*WIDTH +: WIDTH];
    end

    assign full      = (ptr_q == PTR_W'(DEPTH));
    assign empty     = (ptr_q == '0);
    assign req_clash = st_push && st_pop;
    assign push_ok   = (state_q == ST_IDLE) && st_push && !st_pop && !full;
    assign pop_ok    = (state_q == ST_IDLE) && st_pop && !st_push && !empty;

    reg_stack_mem #(
        .FRAME_W (FRAME_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (ptr_q[AW-1:0]),
        .wdata_i (frame_d),
        .raddr_i (ptr_q[AW-1:0]),
        .rdata_o (rd_frame)
    );

    // The strobe is registered off STROBE so the restore buses, loaded on the
    // LOAD edge, are already a full cycle old when st_pop_we rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            err_q    <= 1'b0;
            pop_we_q <= 1'b0;
            out_q    <= '0;
        end else begin
            pop_we_q <= (state_q == ST_STROBE);
            case (state_q)
                ST_IDLE: begin
                    if (req_clash) begin
                        err_q <= 1'b1;
                    end else if (st_push) begin
                        if (full) err_q <= 1'b1;
                        else      ptr_q <= ptr_q + 1'b1;
                    end else if (st_pop) begin
                        if (empty) begin
                            err_q <= 1'b1;
                        end else begin
                            ptr_q   <= ptr_q - 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    out_q   <= rd_frame;
                    state_q <= ST_STROBE;
                end
                ST_STROBE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign st_out1   = out_bus[bus_slot(REG_ACC)];
    assign st_out2   = out_bus[bus_slot(REG_R0)];
    assign st_out3   = out_bus[bus_slot(REG_R1)];
    assign st_out4   = out_bus[bus_slot(REG_R2)];
    assign st_out5   = out_bus[bus_slot(REG_R3)];
    assign st_out6   = out_bus[bus_slot(REG_R4)];
    assign st_out7   = out_bus[bus_slot(REG_R5)];
    assign st_out8   = out_bus[bus_slot(REG_R6)];
    assign st_out9   = out_bus[bus_slot(REG_R7)];
    assign st_pop_we = pop_we_q;
    assign st_busy   = (state_q != ST_IDLE);
    assign st_full   = full;
    assign st_empty  = empty;
    assign st_ptr    = ptr_q;
    assign st_err    = err_q;

    // pop_ok is kept as a named decode for readability of the request rules.
    logic unused_ok;
    assign unused_ok = pop_ok;

endmodule

// File: tb/tb_reg_stack.sv
// Randomized bench for reg_stack against a queue-based LIFO reference model.
module tb_reg_stack;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st_push = 1'b0;
    logic       st_pop = 1'b0;
    logic [7:0] in_b  [9];
    logic [7:0] out_b [9];
    logic       st_pop_we, st_busy, st_full, st_empty, st_err;
    logic [3:0] st_ptr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain LIFO of packed frames plus a sticky error bit.
    logic [71:0] model_q[$];
    logic        err_m;

    always #5 clk = ~clk;

    reg_stack #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .st_push(st_push), .st_pop(st_pop),
        .st_in1(in_b[0]), .st_in2(in_b[1]), .st_in3(in_b[2]), .st_in4(in_b[3]),
        .st_in5(in_b[4]), .st_in6(in_b[5]), .st_in7(in_b[6]), .st_in8(in_b[7]),
        .st_in9(in_b[8]),
        .st_out1(out_b[0]), .st_out2(out_b[1]), .st_out3(out_b[2]), .st_out4(out_b[3]),
        .st_out5(out_b[4]), .st_out6(out_b[5]), .st_out7(out_b[6]), .st_out8(out_b[7]),
        .st_out9(out_b[8]),
        .st_pop_we(st_pop_we), .st_busy(st_busy), .st_full(st_full),
        .st_empty(st_empty), .st_ptr(st_ptr), .st_err(st_err)
    );

    function automatic logic [71:0] out_word();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = out_b[k];
        return w;
    endfunction

    function automatic logic [71:0] rand_frame();
        logic [71:0] f;
        for (int k = 0; k < 9; k++) f[k*8 +: 8] = 8'($urandom_range(0, 255));
        return f;
    endfunction

    task automatic set_in(input logic [71:0] f);
        for (int k = 0; k < 9; k++) in_b[k] = f[k*8 +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_q.delete();
        err_m = 1'b0;
    endtask

    // One push request; updates the model exactly as the push rules state.
    task automatic do_push(input logic [71:0] f);
        set_in(f);
        st_push = 1'b1;
        tick();
        st_push = 1'b0;
        if (model_q.size() == DEPTH) err_m = 1'b1;
        else model_q.push_back(f);
        $display("push   data=%h ptr=%0d err=%0d", f, st_ptr, st_err);
    endtask

    // One pop request followed by four observed cycles after the request edge.
    task automatic run_pop(output logic [3:0] we_seq, output logic [71:0] out1,
                           output logic [71:0] out2, output logic [3:0] ptr_after);
        st_pop = 1'b1;
        we_seq = '0;
        out1 = '0;
        out2 = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) st_pop = 1'b0;
            we_seq[c] = st_pop_we;
            if (c == 1) out1 = out_word();
            if (c == 2) out2 = out_word();
        end
        ptr_after = st_ptr;
        $display("pop    out=%h we_seq=%b ptr=%0d err=%0d", out2, we_seq, ptr_after, st_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 9; k++) in_b[k] = 8'h00;
        err_m = 1'b0;
        #12;
        n_cmp++; if (out_word() !== 72'h0) begin n_bad++; $display("FAIL reset_out got=%h want=0", out_word()); end
        n_cmp++; if (st_pop_we !== 1'b0 || st_busy !== 1'b0) begin n_bad++; $display("FAIL reset_we_busy got=%b%b want=00", st_pop_we, st_busy); end
        n_cmp++; if (st_ptr !== 4'd0 || st_empty !== 1'b1 || st_full !== 1'b0) begin n_bad++; $display("FAIL reset_ptr got ptr=%0d e=%b f=%b want 0/1/0", st_ptr, st_empty, st_full); end
        n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", st_err); end
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        $display("reset  ptr=%0d empty=%0d", st_ptr, st_empty);
    endtask

    task automatic test_single();
        logic [71:0] f, o1, o2;
        logic [3:0]  we, p;
        for (int k = 0; k < 9; k++) f[k*8 +: 8] = 8'((k + 1) * 8'h11);
        do_push(f);
        n_cmp++; if (st_ptr !== 4'd1 || st_empty !== 1'b0) begin n_bad++; $display("FAIL single_push got ptr=%0d e=%b want 1/0", st_ptr, st_empty); end
        run_pop(we, o1, o2, p);
        void'(model_q.pop_back());
        n_cmp++; if (o1 !== f) begin n_bad++; $display("FAIL single_pre_strobe got=%h want=%h", o1, f); end
        n_cmp++; if (o2 !== f) begin n_bad++; $display("FAIL single_at_strobe got=%h want=%h", o2, f); end
        n_cmp++; if (we !== 4'b0100) begin n_bad++; $display("FAIL single_we_seq got=%b want=0100", we); end
        n_cmp++; if (p !== 4'd0 || st_empty !== 1'b1) begin n_bad++; $display("FAIL single_ptr got=%0d want=0", p); end
    endtask

    task automatic test_fill();
        logic [71:0] f, o1, o2, exp;
        logic [3:0]  we, p;
        for (int k = 1; k <= 8; k++) begin
            f = {9{8'(k)}};
            do_push(f);
        end
        n_cmp++; if (st_full !== 1'b1 || st_ptr !== 4'd8) begin n_bad++; $display("FAIL fill_full got f=%b ptr=%0d want 1/8", st_full, st_ptr); end
        n_cmp++; if (st_err !== 1'b0) begin n_bad++; $display("FAIL fill_err_early got=%b want=0", st_err); end
        do_push(rand_frame());
        n_cmp++; if (st_err !== err_m || st_ptr !== 4'd8) begin n_bad++; $display("FAIL fill_overflow got err=%b ptr=%0d want %b/8", st_err, st_ptr, err_m); end
        for (int k = 8; k >= 1; k--) begin
            run_pop(we, o1, o2, p);
            exp = model_q.pop_back();
            n_cmp++; if (o2 !== exp || we !== 4'b0100 || p !== 4'(model_q.size())) begin
                n_bad++; $display("FAIL fill_pop%0d got data=%h we=%b ptr=%0d want %h/0100/%0d", k, o2, we, p, exp, model_q.size());
            end
        end
    endtask

    task automatic test_pop_empty();
        logic [71:0] o1, o2;
        logic [3:0]  we, p;
        apply_reset();
        run_pop(we, o1, o2, p);
        err_m = 1'b1;
        n_cmp++; if (st_err !== err_m || we !== 4'b0000 || p !== 4'd0 || st_busy !== 1'b0) begin
            n_bad++; $display("FAIL pop_empty got err=%b we=%b ptr=%0d busy=%b want 1/0000/0/0", st_err, we, p, st_busy);
        end
    endtask

    task automatic test_push_pop_same();
        logic [71:0] o1, o2, exp;
        logic [3:0]  we, p;
        logic        saw_we;
        apply_reset();
        do_push(rand_frame());
        do_push(rand_frame());
        set_in(rand_frame());
        st_push = 1'b1;
        st_pop  = 1'b1;
        tick();
        st_push = 1'b0;
        st_pop  = 1'b0;
        err_m   = 1'b1;
        saw_we  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            saw_we |= st_pop_we | st_busy;
            tick();
        end
        $display("clash  ptr=%0d err=%0d", st_ptr, st_err);
        n_cmp++; if (st_ptr !== 4'd2 || st_err !== err_m || saw_we !== 1'b0) begin
            n_bad++; $display("FAIL clash got ptr=%0d err=%b act=%b want 2/1/0", st_ptr, st_err, saw_we);
        end
        run_pop(we, o1, o2, p);
        exp = model_q.pop_back();
        n_cmp++; if (o2 !== exp || p !== 4'd1) begin n_bad++; $display("FAIL clash_nowrite got=%h ptr=%0d want=%h/1", o2, p, exp); end
    endtask

    task automatic test_push_in_load();
        logic [71:0] a;
        logic [3:0]  we;
        apply_reset();
        a = rand_frame();
        do_push(a);
        st_pop = 1'b1;
        tick();
        st_pop = 1'b0;
        we[0] = st_pop_we;
        set_in(rand_frame());
        st_push = 1'b1;
        tick();
        st_push = 1'b0;
        we[1] = st_pop_we;
        tick();
        we[2] = st_pop_we;
        tick();
        we[3] = st_pop_we;
        $display("ldpush out=%h we_seq=%b ptr=%0d err=%0d", out_word(), we, st_ptr, st_err);
        n_cmp++; if (we !== 4'b0100 || st_err !== 1'b0 || st_ptr !== 4'd0 || out_word() !== a) begin
            n_bad++; $display("FAIL push_in_load got we=%b err=%b ptr=%0d out=%h want 0100/0/0/%h", we, st_err, st_ptr, out_word(), a);
        end
    endtask

    task automatic test_reset_strobe();
        logic [71:0] a;
        apply_reset();
        a = rand_frame();
        do_push(a);
        st_pop = 1'b1;
        tick();
        st_pop = 1'b0;
        tick();
        tick();
        n_cmp++; if (st_pop_we !== 1'b1 || out_word() !== a) begin n_bad++; $display("FAIL rst_strobe_pre got we=%b out=%h want 1/%h", st_pop_we, out_word(), a); end
        #1 rst_n = 1'b0;
        #1;
        $display("rstpop we=%0d ptr=%0d out=%h", st_pop_we, st_ptr, out_word());
        n_cmp++; if (st_pop_we !== 1'b0 || st_ptr !== 4'd0 || out_word() !== 72'h0 || st_busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_strobe got we=%b ptr=%0d out=%h busy=%b want 0/0/0/0", st_pop_we, st_ptr, out_word(), st_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        err_m = 1'b0;
    endtask

    task automatic test_random();
        logic [71:0] o1, o2, exp;
        logic [3:0]  we, p;
        int          op;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                do_push(rand_frame());
                n_cmp++; if (st_ptr !== 4'(model_q.size()) || st_full !== (model_q.size() == DEPTH)) begin
                    n_bad++; $display("FAIL rand_push%0d got ptr=%0d full=%b want %0d", i, st_ptr, st_full, model_q.size());
                end
            end else if (op < 9) begin
                run_pop(we, o1, o2, p);
                if (model_q.size() == 0) begin
                    err_m = 1'b1;
                    n_cmp++; if (we !== 4'b0000 || p !== 4'd0) begin n_bad++; $display("FAIL rand_pop_empty%0d got we=%b ptr=%0d want 0000/0", i, we, p); end
                end else begin
                    exp = model_q.pop_back();
                    n_cmp++; if (o1 !== exp || we !== 4'b0100 || p !== 4'(model_q.size())) begin
                        n_bad++; $display("FAIL rand_pop%0d got data=%h we=%b ptr=%0d want %h/0100/%0d", i, o1, we, p, exp, model_q.size());
                    end
                end
            end else begin
                st_push = 1'b1;
                st_pop  = 1'b1;
                tick();
                st_push = 1'b0;
                st_pop  = 1'b0;
                err_m   = 1'b1;
                $display("clash  ptr=%0d err=%0d", st_ptr, st_err);
            end
        end
        n_cmp++; if (st_err !== err_m) begin n_bad++; $display("FAIL rand_err got=%b want=%b", st_err, err_m); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_pop_empty();
        test_push_pop_same();
        test_push_in_load();
        test_reset_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
